// File: rtl/seq_div16_pkg.sv
// -----------------------------------------------------------------------------
// div16_pkg
// Shared types and constants for the seq_div16 iterative divider.
//   div_state_e : controller states IDLE / CALC / FIX / DONE
//   DIV_W       : operand and result width
//   CNT_W       : width of the iteration counter
//   DIV0_QUOT   : quotient reported for a zero divisor
//   abs16()     : magnitude of an operand, two's complement when signed
// -----------------------------------------------------------------------------
package div16_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_e;

  localparam int DIV_W = 16;
  localparam int CNT_W = 5;
  localparam logic [DIV_W-1:0] DIV0_QUOT = 16'hFFFF;

  // The most negative value maps onto itself (0x8000), which is still the
  // right unsigned magnitude for the restoring loop.
  function automatic logic [DIV_W-1:0] abs16(input logic [DIV_W-1:0] v,
                                             input logic             is_signed);
    abs16 = (is_signed && v[DIV_W-1]) ? (~v + 16'd1) : v;
  endfunction

endpackage

// File: rtl/seq_div16_if.sv
// -----------------------------------------------------------------------------
// seq_div16_if
// Request/response bundle for the sequential divider.
//   start_i, signed_i, dividend_i, divisor_i : request, driven by the master
//   ready_o, valid_o                         : handshake, driven by the divider
//   quotient_o, remainder_o                  : results, held until next accept
//   div_by_zero_o, overflow_o                : flags, qualified by valid_o
// Modports: master (requester side), slave (divider side).
// -----------------------------------------------------------------------------
interface seq_div16_if;
  import div16_pkg::*;

  logic             start_i;
  logic             signed_i;
  logic [DIV_W-1:0] dividend_i;
  logic [DIV_W-1:0] divisor_i;
  logic             ready_o;
  logic             valid_o;
  logic [DIV_W-1:0] quotient_o;
  logic [DIV_W-1:0] remainder_o;
  logic             div_by_zero_o;
  logic             overflow_o;

  modport master (
    output start_i, signed_i, dividend_i, divisor_i,
    input  ready_o, valid_o, quotient_o, remainder_o, div_by_zero_o, overflow_o
  );

  modport slave (
    input  start_i, signed_i, dividend_i, divisor_i,
    output ready_o, valid_o, quotient_o, remainder_o, div_by_zero_o, overflow_o
  );

endinterface

// File: rtl/seq_div16_step.sv
// -----------------------------------------------------------------------------
// div16_step
// One combinational restoring-division step.
//   p        in  17  current partial remainder
//   dvd_bit  in   1  next dividend bit shifted into the partial remainder
//   divisor  in  16  divisor magnitude
//   p_next   out 17  partial remainder after the step
//   q_bit    out  1  quotient bit produced by the step
// -----------------------------------------------------------------------------
module div16_step
  import div16_pkg::*;
(
  input  logic [DIV_W:0]   p,
  input  logic             dvd_bit,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W:0]   p_next,
  output logic             q_bit
);

  logic [DIV_W:0]   shifted;
  logic [DIV_W+1:0] sum;
  logic             unused_p_msb;

  // The partial remainder is always below the divisor, so its top bit is
  // zero before the shift and only the low 16 bits carry information.
  assign unused_p_msb = p[DIV_W];
  assign shifted      = {p[DIV_W-1:0], dvd_bit};

  // Subtract as add-with-inverted-operand; carry-out set means no borrow.
  assign sum    = {1'b0, shifted} + {1'b0, ~{1'b0, divisor}} + 18'd1;
  assign q_bit  = sum[DIV_W+1];
  assign p_next = q_bit ? sum[DIV_W:0] : shifted;

endmodule

// File: rtl/seq_div16.sv
// -----------------------------------------------------------------------------
// seq_div16
// Iterative radix-2 restoring divider, 16-bit signed/unsigned DIV and REM.
//   clk  in  rising-edge clock
//   rst  in  synchronous, active-high reset
//   bus  seq_div16_if.slave : start/ready/valid handshake, operands, results
// Optional feature, macro SEQ_DIV16_EARLY_EXIT_EN: when the divisor magnitude
// exceeds the dividend magnitude the loop is skipped (Q=0, R=dividend).
// -----------------------------------------------------------------------------
module seq_div16
  import div16_pkg::*;
#(
  parameter int WIDTH = DIV_W
)
(
  input  logic       clk,
  input  logic       rst,
  seq_div16_if.slave bus
);

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [DIV_W:0]   p;
  logic [DIV_W:0]   p_next;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dmag;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             q_bit;
  logic             neg_a;
  logic             neg_b;
  logic             ovf_pend;
  logic             ready;
  logic             valid;
  logic             dbz;
  logic             ovf;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
`ifdef SEQ_DIV16_EARLY_EXIT_EN
  logic             early;
`endif

  assign a_mag = abs16(bus.dividend_i, bus.signed_i);
  assign b_mag = abs16(bus.divisor_i, bus.signed_i);

  // dvd doubles as the quotient register: dividend bits leave at the top
  // while quotient bits enter at the bottom.
  div16_step u_step (
    .p       (p),
    .dvd_bit (dvd[WIDTH-1]),
    .divisor (dmag),
    .p_next  (p_next),
    .q_bit   (q_bit)
  );

  // Controller: outputs change only on accept of a zero divisor, in FIX,
  // and on the DONE->IDLE edge, so results hold until the next update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      p        <= '0;
      dvd      <= '0;
      dmag     <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      ovf_pend <= 1'b0;
      ready    <= 1'b1;
      valid    <= 1'b0;
      dbz      <= 1'b0;
      ovf      <= 1'b0;
      quot     <= '0;
      rem      <= '0;
`ifdef SEQ_DIV16_EARLY_EXIT_EN
      early    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            ready <= 1'b0;
            if (bus.divisor_i == '0) begin
              quot  <= DIV0_QUOT;
              rem   <= bus.dividend_i;
              dbz   <= 1'b1;
              ovf   <= 1'b0;
              valid <= 1'b1;
              state <= DONE;
            end else begin
              neg_a    <= bus.signed_i & bus.dividend_i[WIDTH-1];
              neg_b    <= bus.signed_i & bus.divisor_i[WIDTH-1];
              ovf_pend <= bus.signed_i && (bus.dividend_i == 16'h8000)
                          && (bus.divisor_i == 16'hFFFF);
              dvd      <= a_mag;
              dmag     <= b_mag;
              p        <= '0;
              cnt      <= '0;
`ifdef SEQ_DIV16_EARLY_EXIT_EN
              early    <= (b_mag > a_mag);
`endif
              state    <= CALC;
            end
          end
        end

        CALC: begin
`ifdef SEQ_DIV16_EARLY_EXIT_EN
          // The shortcut is decided at accept but applied here, keeping the
          // magnitude compare off the path into the iteration registers.
          if (early) begin
            p     <= {1'b0, dvd};
            dvd   <= '0;
            early <= 1'b0;
            state <= FIX;
          end else begin
            p   <= p_next;
            dvd <= {dvd[WIDTH-2:0], q_bit};
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(DIV_W - 1)) state <= FIX;
          end
`else
          p   <= p_next;
          dvd <= {dvd[WIDTH-2:0], q_bit};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(DIV_W - 1)) state <= FIX;
`endif
        end

        FIX: begin
          // neg_a/neg_b are already zero in unsigned mode.
          quot  <= (neg_a ^ neg_b) ? (~dvd + 16'd1) : dvd;
          rem   <= neg_a ? (~p[WIDTH-1:0] + 16'd1) : p[WIDTH-1:0];
          dbz   <= 1'b0;
          ovf   <= ovf_pend;
          valid <= 1'b1;
          state <= DONE;
        end

        DONE: begin
          valid <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end

        default: begin
          valid <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready_o       = ready;
  assign bus.valid_o       = valid;
  assign bus.quotient_o    = quot;
  assign bus.remainder_o   = rem;
  assign bus.div_by_zero_o = dbz;
  assign bus.overflow_o    = ovf;

endmodule

// File: tb/tb_seq_div16.sv
// -----------------------------------------------------------------------------
// tb_seq_div16
// Directed, table-driven bench for seq_div16. Latency is measured as the
// number of clock edges from the accept edge to the edge that raises valid_o.
// Honours SEQ_DIV16_EARLY_EXIT_EN for the expected latency of short cases.
// -----------------------------------------------------------------------------
module tb_seq_div16;

  localparam int NORM_LAT = 17;
  localparam int DBZ_LAT  = 0;
`ifdef SEQ_DIV16_EARLY_EXIT_EN
  localparam int EARLY_LAT = 2;
`else
  localparam int EARLY_LAT = NORM_LAT;
`endif

  typedef struct {
    logic        sgn;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    logic        ovf;
    logic        early;
  } vec_t;

  logic clk;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   acc   = 0;

  seq_div16_if bus();

  seq_div16 #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock and an edge counter used for latency measurement.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Guards against a hung handshake.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits for ready, presents one request across an edge, records the
  // accept edge. With hold set, start_i stays high afterwards.
  task automatic applyStimulus(input logic sgn, input logic [15:0] a,
                               input logic [15:0] b, input logic hold);
    int guard = 0;
    while (bus.ready_o !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("ready before start", 32'(bus.ready_o), 32'd1);
    bus.signed_i   = sgn;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    bus.start_i    = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    if (!hold) bus.start_i = 1'b0;
  endtask

  task automatic waitValid(output int lat);
    while (bus.valid_o !== 1'b1 && (cyc - acc) < 40) begin
      @(posedge clk); #1;
    end
    lat = (bus.valid_o === 1'b1) ? (cyc - acc) : -1;
  endtask

  vec_t vecs[14];
  int   lat;
  int   exp_lat;
  int   saw_valid;

  initial begin
    vecs[0]  = '{1'b0, 16'd100,   16'd7,    16'd14,   16'd2,    1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 16'hFF9C,  16'h0007, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 16'h8000,  16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 16'h1234,  16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 16'h1234,  16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 16'hFFFF,  16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 16'h8000,  16'hFFFF, 16'h0000, 16'h8000, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 16'd100,   16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 16'hFF9C,  16'hFFF9, 16'h000E, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 16'hFFFF,  16'h00FF, 16'h0101, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 16'd5,     16'd9,    16'h0000, 16'h0005, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 16'd1000,  16'h8000, 16'h0000, 16'h03E8, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 16'h7FFF,  16'h0002, 16'h3FFF, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 16'h8000,  16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0};

    rst            = 1'b1;
    bus.start_i    = 1'b0;
    bus.signed_i   = 1'b0;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("reset ready", 32'(bus.ready_o), 32'd1);
    checkOutput("reset valid", 32'(bus.valid_o), 32'd0);
    checkOutput("reset quotient", 32'(bus.quotient_o), 32'd0);
    checkOutput("reset remainder", 32'(bus.remainder_o), 32'd0);
    checkOutput("reset div_by_zero", 32'(bus.div_by_zero_o), 32'd0);
    checkOutput("reset overflow", 32'(bus.overflow_o), 32'd0);

    $display("[TB] vector table");
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b, 1'b0);
      waitValid(lat);
      exp_lat = (vecs[i].b == 16'd0) ? DBZ_LAT :
                (vecs[i].early ? EARLY_LAT : NORM_LAT);
      checkOutput($sformatf("v%0d latency", i), 32'(lat), 32'(exp_lat));
      checkOutput($sformatf("v%0d quotient", i), 32'(bus.quotient_o), 32'(vecs[i].q));
      checkOutput($sformatf("v%0d remainder", i), 32'(bus.remainder_o), 32'(vecs[i].r));
      checkOutput($sformatf("v%0d div_by_zero", i), 32'(bus.div_by_zero_o), 32'(vecs[i].dbz));
      checkOutput($sformatf("v%0d overflow", i), 32'(bus.overflow_o), 32'(vecs[i].ovf));
      @(posedge clk); #1;
      checkOutput($sformatf("v%0d valid one cycle", i), 32'(bus.valid_o), 32'd0);
      checkOutput($sformatf("v%0d ready after done", i), 32'(bus.ready_o), 32'd1);
      @(posedge clk); #1;
      checkOutput($sformatf("v%0d quotient held", i), 32'(bus.quotient_o), 32'(vecs[i].q));
    end

    $display("[TB] start held through busy period");
    applyStimulus(1'b0, 16'd100, 16'd7, 1'b1);
    bus.dividend_i = 16'd200;
    bus.divisor_i  = 16'd3;
    repeat (5) begin
      @(posedge clk); #1;
    end
    checkOutput("busy ready low", 32'(bus.ready_o), 32'd0);
    checkOutput("busy old quotient kept", 32'(bus.quotient_o), 32'(vecs[13].q));
    waitValid(lat);
    checkOutput("held first latency", 32'(lat), 32'(NORM_LAT));
    checkOutput("held first quotient", 32'(bus.quotient_o), 32'd14);
    checkOutput("held first remainder", 32'(bus.remainder_o), 32'd2);
    @(posedge clk); #1;
    checkOutput("held no accept in done", 32'(bus.ready_o), 32'd1);
    checkOutput("held quotient stable", 32'(bus.quotient_o), 32'd14);
    @(posedge clk); #1;
    acc = cyc;
    bus.start_i = 1'b0;
    checkOutput("held second accepted", 32'(bus.ready_o), 32'd0);
    waitValid(lat);
    checkOutput("held second latency", 32'(lat), 32'(NORM_LAT));
    checkOutput("held second quotient", 32'(bus.quotient_o), 32'd66);
    checkOutput("held second remainder", 32'(bus.remainder_o), 32'd2);
    @(posedge clk); #1;

    $display("[TB] reset during CALC");
    applyStimulus(1'b0, 16'h1234, 16'd3, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort ready", 32'(bus.ready_o), 32'd1);
    checkOutput("abort valid", 32'(bus.valid_o), 32'd0);
    checkOutput("abort quotient", 32'(bus.quotient_o), 32'd0);
    checkOutput("abort remainder", 32'(bus.remainder_o), 32'd0);
    checkOutput("abort div_by_zero", 32'(bus.div_by_zero_o), 32'd0);
    checkOutput("abort overflow", 32'(bus.overflow_o), 32'd0);
    saw_valid = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.valid_o === 1'b1) saw_valid = 1;
    end
    checkOutput("abort no late valid", 32'(saw_valid), 32'd0);

    $display("[TB] recovery after abort");
    applyStimulus(1'b1, 16'hFF9C, 16'h0007, 1'b0);
    waitValid(lat);
    checkOutput("recover latency", 32'(lat), 32'(NORM_LAT));
    checkOutput("recover quotient", 32'(bus.quotient_o), 32'hFFF2);
    checkOutput("recover remainder", 32'(bus.remainder_o), 32'hFFFE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
